rr_module: RTL and testbench

Self-contained melody player for the RickRoll project: plays a fixed 16-note phrase from an internal ROM as a square-wave tone and loops forever. It is the whole design under the simulation top. It has no output ports, so all observation is through the named internal signals below, which are part of the contract. It is kept simulation-scaled so several loops fit in about 100k clock cycles.

---
 rtl/rr_module.sv | 127 ++++++++++++
 tb/tb_rr_module.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_module.sv
`default_nettype none
// ============================================================================
//  Module      : rr_module
//  Description : Self-contained melody player. Steps through a fixed 16-entry
//                phrase ROM, generates a square-wave tone for each note and
//                loops forever, counting completed phrases.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_module #(
    parameter int TICKS_PER_BEAT = 256,
    parameter int LOOP_W         = 8
) (
    input  wire logic clock,
    input  wire logic reset
);

    // Observable state (names and widths are part of the probe contract)
    logic [3:0]        note_index;
    logic [15:0]       dur_cnt;
    logic [7:0]        div_cnt;
    logic              tone;
    logic              note_strobe;
    logic [LOOP_W-1:0] loop_count;

    // Pitch code to tone half-period in cycles; 0 means rest
    function automatic logic [7:0] pitch_half(input logic [3:0] code);
        logic [7:0] h;
        case (code)
            4'd1:    h = 8'd48;
            4'd2:    h = 8'd45;
            4'd3:    h = 8'd43;
            4'd4:    h = 8'd40;
            4'd5:    h = 8'd38;
            4'd6:    h = 8'd36;
            4'd7:    h = 8'd34;
            4'd8:    h = 8'd32;
            4'd9:    h = 8'd30;
            4'd10:   h = 8'd28;
            4'd11:   h = 8'd27;
            4'd12:   h = 8'd25;
            default: h = 8'd0;
        endcase
        return h;
    endfunction

    // Melody ROM: pitch code of each entry
    function automatic logic [3:0] melody_code(input logic [3:0] idx);
        logic [3:0] c;
        case (idx)
            4'd0, 4'd8:   c = 4'd1;
            4'd1, 4'd9:   c = 4'd3;
            4'd2, 4'd10:  c = 4'd6;
            4'd3, 4'd11:  c = 4'd3;
            4'd4, 4'd5:   c = 4'd10;
            4'd6:         c = 4'd8;
            4'd12, 4'd13: c = 4'd8;
            4'd14:        c = 4'd6;
            default:      c = 4'd0;
        endcase
        return c;
    endfunction

    // Melody ROM: length of each entry in beats
    function automatic logic [2:0] melody_beats(input logic [3:0] idx);
        logic [2:0] b;
        case (idx)
            4'd4, 4'd5, 4'd12, 4'd13, 4'd14: b = 3'd3;
            4'd6:                            b = 3'd6;
            default:                         b = 3'd1;
        endcase
        return b;
    endfunction

    logic [3:0]  w_code;
    logic [7:0]  w_half;
    logic [31:0] w_dur;
    logic        w_is_rest;
    logic        w_note_end;
    logic        w_tone_end;

    // Decode the current ROM entry into its duration and tone half-period
    always_comb begin
        w_code     = melody_code(note_index);
        w_half     = pitch_half(w_code);
        w_dur      = {29'd0, melody_beats(note_index)} * TICKS_PER_BEAT;
        w_is_rest  = (w_half == 8'd0);
        w_note_end = ({16'd0, dur_cnt} == (w_dur - 32'd1));
        w_tone_end = (div_cnt == (w_half - 8'd1));
    end

    // Note sequencing and tone generation; a note advance overrides any toggle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            note_index  <= 4'd0;
            dur_cnt     <= 16'd0;
            div_cnt     <= 8'd0;
            tone        <= 1'b0;
            note_strobe <= 1'b0;
            loop_count  <= '0;
        end else begin
            note_strobe <= 1'b0;
            if (w_note_end) begin
                dur_cnt     <= 16'd0;
                note_index  <= note_index + 4'd1;
                div_cnt     <= 8'd0;
                tone        <= 1'b0;
                note_strobe <= 1'b1;
                if (note_index == 4'd15) begin
                    loop_count <= loop_count + 1'b1;
                end
            end else begin
                dur_cnt <= dur_cnt + 16'd1;
                if (w_is_rest) begin
                    div_cnt <= 8'd0;
                    tone    <= 1'b0;
                end else if (w_tone_end) begin
                    div_cnt <= 8'd0;
                    tone    <= ~tone;
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_module.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_module
//  Description : Directed self-checking bench for rr_module (default timing
//                instance plus a fast instance with TICKS_PER_BEAT = 4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_module;

    logic clk;
    logic reset;

    int n_cmp;
    int n_err;
    int e;
    int rest_err;
    int pat_err;
    int strobe_hi;
    int fast_tone_hi;
    logic loop1_tone [1:7936];

    rr_module dut (
        .clock (clk),
        .reset (reset)
    );

    rr_module #(.TICKS_PER_BEAT(4)) dut_fast (
        .clock (clk),
        .reset (reset)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts and reports mismatches
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, e);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; e = 0;
        rest_err = 0; pat_err = 0; strobe_hi = 0; fast_tone_hi = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_eq("rst_note_index", 32'(dut.note_index), 32'd0);
        check_eq("rst_dur_cnt",    32'(dut.dur_cnt),    32'd0);
        check_eq("rst_div_cnt",    32'(dut.div_cnt),    32'd0);
        check_eq("rst_tone",       32'(dut.tone),       32'd0);
        check_eq("rst_strobe",     32'(dut.note_strobe),32'd0);
        check_eq("rst_loop",       32'(dut.loop_count), 32'd0);
        // release between edges (posedges at 5,15,25,...)
        #28 reset = 1'b1;

        for (int k = 0; k < 17072; k++) begin
            step();
            // per-edge observations
            if (e <= 7936) loop1_tone[e] = dut.tone;
            else if (e <= 15872 && dut.tone !== loop1_tone[e - 7936]) pat_err++;
            if (e <= 7936 && dut.note_strobe) strobe_hi++;
            if (e >= 4097 && e <= 4351 && (dut.tone !== 1'b0 || dut.div_cnt !== 8'd0)) rest_err++;
            if (dut_fast.tone) fast_tone_hi++;

            // edge-specific checks on the default instance
            case (e)
                1: begin
                    check_eq("e1_dur_cnt",    32'(dut.dur_cnt),    32'd1);
                    check_eq("e1_note_index", 32'(dut.note_index), 32'd0);
                end
                47:   check_eq("n0_tone_e47",  32'(dut.tone), 32'd0);
                48: begin
                    check_eq("n0_tone_e48",  32'(dut.tone), 32'd1);
                    check_eq("n0_div_e48",   32'(dut.div_cnt), 32'd0);
                end
                95:   check_eq("n0_tone_e95",  32'(dut.tone), 32'd1);
                96:   check_eq("n0_tone_e96",  32'(dut.tone), 32'd0);
                144:  check_eq("n0_tone_e144", 32'(dut.tone), 32'd1);
                255: begin
                    check_eq("n0_idx_e255",  32'(dut.note_index), 32'd0);
                    check_eq("n0_tone_e255", 32'(dut.tone), 32'd1);
                    check_eq("n0_strb_e255", 32'(dut.note_strobe), 32'd0);
                end
                256: begin
                    check_eq("adv_idx_e256",  32'(dut.note_index), 32'd1);
                    check_eq("adv_strb_e256", 32'(dut.note_strobe), 32'd1);
                    check_eq("adv_dur_e256",  32'(dut.dur_cnt), 32'd0);
                    check_eq("adv_tone_e256", 32'(dut.tone), 32'd0);
                end
                257: begin
                    check_eq("adv_strb_e257", 32'(dut.note_strobe), 32'd0);
                    check_eq("adv_dur_e257",  32'(dut.dur_cnt), 32'd1);
                end
                298:  check_eq("n1_tone_e298", 32'(dut.tone), 32'd0);
                299:  check_eq("n1_tone_e299", 32'(dut.tone), 32'd1);
                1051: check_eq("n4_tone_e1051", 32'(dut.tone), 32'd0);
                1052: check_eq("n4_tone_e1052", 32'(dut.tone), 32'd1);
                1080: check_eq("n4_tone_e1080", 32'(dut.tone), 32'd0);
                1791: begin
                    check_eq("n4_idx_e1791",  32'(dut.note_index), 32'd4);
                    check_eq("n4_tone_e1791", 32'(dut.tone), 32'd1);
                end
                1792: begin
                    check_eq("n4_idx_e1792",  32'(dut.note_index), 32'd5);
                    check_eq("n4_tone_e1792", 32'(dut.tone), 32'd0);
                    check_eq("n4_div_e1792",  32'(dut.div_cnt), 32'd0);
                end
                1793: check_eq("n5_div_e1793",  32'(dut.div_cnt), 32'd1);
                1819: check_eq("n5_tone_e1819", 32'(dut.tone), 32'd0);
                1820: check_eq("n5_tone_e1820", 32'(dut.tone), 32'd1);
                4096: check_eq("n7_idx_e4096",  32'(dut.note_index), 32'd7);
                4352: begin
                    check_eq("n7_idx_e4352", 32'(dut.note_index), 32'd8);
                    check_eq("n7_rest",      32'(rest_err), 32'd0);
                end
                7935: begin
                    check_eq("wrap_idx_e7935",  32'(dut.note_index), 32'd15);
                    check_eq("wrap_loop_e7935", 32'(dut.loop_count), 32'd0);
                end
                7936: begin
                    check_eq("wrap_idx_e7936",  32'(dut.note_index), 32'd0);
                    check_eq("wrap_loop_e7936", 32'(dut.loop_count), 32'd1);
                    check_eq("wrap_strb_e7936", 32'(dut.note_strobe), 32'd1);
                    check_eq("loop1_strobes",   32'(strobe_hi), 32'd16);
                end
                15872: begin
                    check_eq("wrap_loop_e15872", 32'(dut.loop_count), 32'd2);
                    check_eq("wrap_idx_e15872",  32'(dut.note_index), 32'd0);
                    check_eq("loop2_pattern",    32'(pat_err), 32'd0);
                end
                17072: begin
                    check_eq("mid_n4_idx", 32'(dut.note_index), 32'd4);
                    check_eq("mid_n4_dur", 32'(dut.dur_cnt), 32'd176);
                end
                default: ;
            endcase

            // fast instance (TICKS_PER_BEAT = 4, one loop = 124 edges)
            case (e)
                3:   check_eq("fast_idx_e3", 32'(dut_fast.note_index), 32'd0);
                4: begin
                    check_eq("fast_idx_e4", 32'(dut_fast.note_index), 32'd1);
                    check_eq("fast_dur_e4", 32'(dut_fast.dur_cnt), 32'd0);
                end
                123: begin
                    check_eq("fast_idx_e123",  32'(dut_fast.note_index), 32'd15);
                    check_eq("fast_loop_e123", 32'(dut_fast.loop_count), 32'd0);
                end
                124: begin
                    check_eq("fast_idx_e124",  32'(dut_fast.note_index), 32'd0);
                    check_eq("fast_loop_e124", 32'(dut_fast.loop_count), 32'd1);
                end
                248: check_eq("fast_loop_e248", 32'(dut_fast.loop_count), 32'd2);
                default: ;
            endcase
        end

        check_eq("fast_tone_never", 32'(fast_tone_hi), 32'd0);

        // asynchronous reset mid-note 4, between clock edges
        #2 reset = 1'b0;
        #1;
        check_eq("arst_note_index", 32'(dut.note_index), 32'd0);
        check_eq("arst_dur_cnt",    32'(dut.dur_cnt),    32'd0);
        check_eq("arst_div_cnt",    32'(dut.div_cnt),    32'd0);
        check_eq("arst_tone",       32'(dut.tone),       32'd0);
        check_eq("arst_strobe",     32'(dut.note_strobe),32'd0);
        check_eq("arst_loop",       32'(dut.loop_count), 32'd0);
        check_eq("arst_fast_loop",  32'(dut_fast.loop_count), 32'd0);
        step();
        step();
        #3 reset = 1'b1;
        e = 0;
        step();
        check_eq("rel_dur_cnt",    32'(dut.dur_cnt),    32'd1);
        check_eq("rel_note_index", 32'(dut.note_index), 32'd0);
        check_eq("rel_loop",       32'(dut.loop_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
